// File: rtl/rsa_pkg.sv
// Shared RSA datapath constants and the result-unloader state type.
// ABITS/DBITS defaults must track the bram and mon_prod instances.
package rsa_pkg;

    localparam int ABITS_DEF      = 8;
    localparam int DBITS_DEF      = 512;
    localparam int OBITS_DEF      = 32;
    localparam int NWORDS_DEF     = 2;
    localparam int BEATS_PER_WORD = DBITS_DEF / OBITS_DEF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_CAPT,
        ST_SEND
    } unl_state_t;

    // Counter width that never collapses to zero bits for a count of one.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/result_unloader_if.sv
// Control, BRAM read-port and output-stream signals of the result unloader.
// slave = the unloader itself, master = whoever drives it (host glue / bench).
interface result_unloader_if
    import rsa_pkg::*;
#(
    parameter int ABITS = ABITS_DEF,
    parameter int DBITS = DBITS_DEF,
    parameter int OBITS = OBITS_DEF
);

    logic             start;
    logic [ABITS-1:0] base_addr;
    logic             busy;
    logic             done;
    logic [ABITS-1:0] rd_addr;
    logic [DBITS-1:0] rd_data;
    logic [OBITS-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;

    modport slave (
        input  start, base_addr, rd_data, out_ready,
        output rd_addr, out_data, out_valid, out_last, busy, done
    );

    modport master (
        output start, base_addr, rd_data, out_ready,
        input  rd_addr, out_data, out_valid, out_last, busy, done
    );

endinterface

// File: rtl/word_serializer.sv
// DBITS-to-OBITS shift register with a beat counter; emits LSB chunk first,
// or MSB chunk first when RESULT_UNLOADER_MSB_FIRST_EN is defined.
module word_serializer
    import rsa_pkg::*;
#(
    parameter int DBITS = DBITS_DEF,
    parameter int OBITS = OBITS_DEF,
    parameter int BEATS = BEATS_PER_WORD
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [DBITS-1:0] i_data,
    input  logic             i_shift,
    output logic [OBITS-1:0] o_chunk,
    output logic             o_last_beat
);

    localparam int CW = cnt_width(BEATS);

    logic [DBITS-1:0] r_shift;
    logic [CW-1:0]    r_beat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_beat  <= '0;
        end else if (i_load) begin
            r_shift <= i_data;
            r_beat  <= '0;
        end else if (i_shift) begin
`ifdef RESULT_UNLOADER_MSB_FIRST_EN
            r_shift <= r_shift << OBITS;
`else
            r_shift <= r_shift >> OBITS;
`endif
            r_beat  <= r_beat + 1'b1;
        end
    end

`ifdef RESULT_UNLOADER_MSB_FIRST_EN
    assign o_chunk = r_shift[DBITS-1 -: OBITS];
`else
    assign o_chunk = r_shift[OBITS-1:0];
`endif

    assign o_last_beat = (r_beat == CW'(BEATS - 1));

endmodule

// File: rtl/result_unloader.sv
// Reads an NWORDS-word result from BRAM and streams it out OBITS at a time.
// RESULT_UNLOADER_MSB_FIRST_EN: most-significant word and chunk go out first.
module result_unloader
    import rsa_pkg::*;
#(
    parameter int ABITS  = ABITS_DEF,
    parameter int DBITS  = DBITS_DEF,
    parameter int OBITS  = OBITS_DEF,
    parameter int NWORDS = NWORDS_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    result_unloader_if.slave   bus
);

    localparam int BEATS = DBITS / OBITS;
    localparam int WCW   = cnt_width(NWORDS);

    generate
        if (DBITS % OBITS != 0) begin : g_width_check
            $error("result_unloader: DBITS must be a multiple of OBITS");
        end
    endgenerate

    unl_state_t       r_state;
    unl_state_t       w_state_next;
    logic [ABITS-1:0] r_rd_addr;
    logic [WCW-1:0]   r_word;
    logic             r_done;

    logic             w_valid;
    logic             w_load;
    logic             w_fire;
    logic             w_last_out;
    logic             w_busy;
    logic             w_start_ok;
    logic             w_last_beat;
    logic             w_last_word;
    logic [OBITS-1:0] w_chunk;

    assign w_last_word = (r_word == WCW'(NWORDS - 1));
    assign w_fire      = w_valid & bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE: if (bus.start) w_state_next = ST_ADDR;
            ST_ADDR: w_state_next = ST_CAPT;
            ST_CAPT: w_state_next = ST_SEND;
            ST_SEND: if (w_fire && w_last_beat)
                         w_state_next = w_last_word ? ST_IDLE : ST_ADDR;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_valid    = (r_state == ST_SEND);
        w_load     = (r_state == ST_CAPT);
        w_busy     = (r_state != ST_IDLE);
        w_start_ok = (r_state == ST_IDLE) & bus.start;
        w_last_out = w_valid & w_last_word & w_last_beat;
    end

    // Address walks up from base (LSB first) or down from base+NWORDS-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_addr <= '0;
            r_word    <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= w_fire & w_last_out;
            if (w_start_ok) begin
`ifdef RESULT_UNLOADER_MSB_FIRST_EN
                r_rd_addr <= bus.base_addr + ABITS'(NWORDS - 1);
`else
                r_rd_addr <= bus.base_addr;
`endif
                r_word    <= '0;
            end else if (w_fire && w_last_beat && !w_last_word) begin
`ifdef RESULT_UNLOADER_MSB_FIRST_EN
                r_rd_addr <= r_rd_addr - 1'b1;
`else
                r_rd_addr <= r_rd_addr + 1'b1;
`endif
                r_word    <= r_word + 1'b1;
            end
        end
    end

    word_serializer #(
        .DBITS (DBITS),
        .OBITS (OBITS),
        .BEATS (BEATS)
    ) u_ser (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_load      (w_load),
        .i_data      (bus.rd_data),
        .i_shift     (w_fire),
        .o_chunk     (w_chunk),
        .o_last_beat (w_last_beat)
    );

    // Outputs are gated by SEND so they read zero in every other state.
    assign bus.rd_addr   = r_rd_addr;
    assign bus.out_data  = w_valid ? w_chunk : '0;
    assign bus.out_valid = w_valid;
    assign bus.out_last  = w_last_out;
    assign bus.busy      = w_busy;
    assign bus.done      = r_done;

endmodule

// File: tb/tb_result_unloader.sv
// Directed bench for result_unloader: table of transfers plus reset-abort sequence.
// Expectations follow RESULT_UNLOADER_MSB_FIRST_EN when it is defined.
module tb_result_unloader;
    import rsa_pkg::*;

    localparam int TOTAL = NWORDS_DEF * BEATS_PER_WORD;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    result_unloader_if bus ();

    result_unloader dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    logic [DBITS_DEF-1:0] mem [256];
    always @(posedge clk) bus.rd_data <= mem[bus.rd_addr];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic [7:0]  base;
        logic [31:0] v_lo;     // low 32 bits of word at base
        logic [31:0] v_hi;     // low 32 bits of word at base+1
        int          idx_lo;   // beat index where v_lo must appear
        int          idx_hi;   // beat index where v_hi must appear
        logic [7:0]  addr_a;   // first word address read
        logic [7:0]  addr_b;   // second word address read
        bit          rnd_ready;
        bit          poke_start;
    } vec_t;

    vec_t vecs [4];

    function automatic logic [31:0] exp_beat(input vec_t v, input int k);
        if (k == v.idx_lo) return v.v_lo;
        if (k == v.idx_hi) return v.v_hi;
        return 32'h0;
    endfunction

    task automatic run_xfer(input vec_t v, input bit prestarted, input bit chain, input logic [7:0] next_base);
        logic [7:0]  hi_addr;
        logic [31:0] held_data;
        logic        held_last;
        logic        rdy;
        bit          stalled;
        int          beat;
        int          cycles;
        int          bubbles;
        hi_addr = v.base + 8'd1;
        mem[v.base] = {480'b0, v.v_lo};
        mem[hi_addr] = {480'b0, v.v_hi};
        if (!prestarted) begin
            @(negedge clk);
            bus.base_addr = v.base;
            bus.start = 1'b1;
        end
        @(negedge clk);
        bus.start = 1'b0;
        chk({v.name, ".busy_addr"}, bus.busy, 1'b1);
        chk({v.name, ".rd_addr_a"}, bus.rd_addr, v.addr_a);
        chk({v.name, ".valid_addr"}, bus.out_valid, 1'b0);
        @(negedge clk);
        chk({v.name, ".valid_capt"}, bus.out_valid, 1'b0);
        beat = 0; cycles = 0; bubbles = 0; stalled = 0;
        held_data = '0; held_last = 1'b0;
        while (beat < TOTAL && cycles < 1000) begin
            @(negedge clk);
            cycles++;
            if (cycles == 1) chk({v.name, ".latency"}, bus.out_valid, 1'b1);
            if (stalled) begin
                chk({v.name, ".stall_valid"}, bus.out_valid, 1'b1);
                chk({v.name, ".stall_data"}, bus.out_data, held_data);
                chk({v.name, ".stall_last"}, bus.out_last, held_last);
            end
            if (!bus.out_valid) bubbles++;
            bus.start = v.poke_start && (cycles == 8);
            if (v.poke_start && cycles == 8) bus.base_addr = 8'h55;
            rdy = v.rnd_ready ? ($urandom_range(0, 99) < 55) : 1'b1;
            bus.out_ready = rdy;
            stalled = 0;
            if (bus.out_valid) begin
                if (rdy) begin
                    chk($sformatf("%s.data[%0d]", v.name, beat), bus.out_data, exp_beat(v, beat));
                    chk($sformatf("%s.last[%0d]", v.name, beat), bus.out_last, beat == TOTAL - 1);
                    if (beat == BEATS_PER_WORD) chk({v.name, ".rd_addr_b"}, bus.rd_addr, v.addr_b);
                    beat++;
                end else begin
                    stalled   = 1;
                    held_data = bus.out_data;
                    held_last = bus.out_last;
                end
            end
        end
        bus.start = 1'b0;
        chk({v.name, ".beat_count"}, beat, TOTAL);
        chk({v.name, ".bubbles"}, bubbles, 2);
        @(negedge clk);
        chk({v.name, ".done"}, bus.done, 1'b1);
        chk({v.name, ".busy_done"}, bus.busy, 1'b0);
        if (chain) begin
            bus.base_addr = next_base;
            bus.start = 1'b1;
        end else begin
            @(negedge clk);
            chk({v.name, ".done_pulse"}, bus.done, 1'b0);
            chk({v.name, ".idle_after"}, bus.busy, 1'b0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        bus.start = 1'b0;
        bus.base_addr = '0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = '0;

`ifdef RESULT_UNLOADER_MSB_FIRST_EN
        vecs[0] = '{"ld435", 8'd4,   32'd435,    32'd0,      31, 15, 8'd5,   8'd4,   1'b0, 1'b0};
        vecs[1] = '{"mix",   8'd0,   32'd589,    32'd1,      31, 15, 8'd1,   8'd0,   1'b1, 1'b0};
        vecs[2] = '{"wrap",  8'd255, 32'h1234,   32'hBEEF,   31, 15, 8'd0,   8'd255, 1'b0, 1'b0};
        vecs[3] = '{"poke",  8'd100, 32'd7,      32'd9,      31, 15, 8'd101, 8'd100, 1'b1, 1'b1};
`else
        vecs[0] = '{"ld435", 8'd4,   32'd435,    32'd0,      0,  16, 8'd4,   8'd5,   1'b0, 1'b0};
        vecs[1] = '{"mix",   8'd0,   32'd589,    32'd1,      0,  16, 8'd0,   8'd1,   1'b1, 1'b0};
        vecs[2] = '{"wrap",  8'd255, 32'h1234,   32'hBEEF,   0,  16, 8'd255, 8'd0,   1'b0, 1'b0};
        vecs[3] = '{"poke",  8'd100, 32'd7,      32'd9,      0,  16, 8'd100, 8'd101, 1'b1, 1'b1};
`endif

        repeat (3) @(negedge clk);
        chk("reset.rd_addr", bus.rd_addr, 8'd0);
        chk("reset.out_data", bus.out_data, 32'd0);
        chk("reset.out_valid", bus.out_valid, 1'b0);
        chk("reset.out_last", bus.out_last, 1'b0);
        chk("reset.busy", bus.busy, 1'b0);
        chk("reset.done", bus.done, 1'b0);
        rst_n = 1'b1;

        run_xfer(vecs[0], 1'b0, 1'b0, 8'd0);
        run_xfer(vecs[1], 1'b0, 1'b0, 8'd0);
        run_xfer(vecs[2], 1'b0, 1'b1, vecs[3].base);
        run_xfer(vecs[3], 1'b1, 1'b0, 8'd0);

        // Abort a transfer at beat 10 with an all-ones word so the reset is visible on out_data.
        mem[20] = '1;
        mem[21] = '1;
        @(negedge clk);
        bus.base_addr = 8'd20;
        bus.start = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        acc = 0;
        for (int c = 0; c < 100 && acc < 10; c++) begin
            @(negedge clk);
            if (bus.out_valid) acc++;
        end
        @(negedge clk);
        chk("abort.pre_valid", bus.out_valid, 1'b1);
        chk("abort.pre_data", bus.out_data, 32'hFFFF_FFFF);
        rst_n = 1'b0;
        #1;
        chk("abort.out_valid", bus.out_valid, 1'b0);
        chk("abort.out_data", bus.out_data, 32'd0);
        chk("abort.out_last", bus.out_last, 1'b0);
        chk("abort.busy", bus.busy, 1'b0);
        chk("abort.done", bus.done, 1'b0);
        chk("abort.rd_addr", bus.rd_addr, 8'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("abort.no_done", bus.done, 1'b0);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("abort.idle_done", bus.done, 1'b0);
            chk("abort.idle_busy", bus.busy, 1'b0);
        end
        run_xfer(vecs[0], 1'b0, 1'b0, 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/result_unloader.md
# result_unloader

Reads a multi-word result (e.g. the 1024-bit Montgomery product that `mon_prod` writes back) out of the operand/result BRAM through its registered read port, and serializes it onto a narrow valid/ready stream toward the host interface. It is the reader for what `mon_prod` writes: it replaces hand-probing `P`, and pairs with the BRAM port-2 operand loader on the input side. The top level grants it the BRAM read port only while `mon_prod` is idle.

## Interface
- `ABITS`, 8, BRAM address width
- `DBITS`, 512, BRAM word width
- `OBITS`, 32, output stream width; `DBITS % OBITS == 0` is required, with an elaboration error otherwise
- `NWORDS`, 2, BRAM words per result (1024-bit value)
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  single-cycle request; sampled only in IDLE
- `base_addr`  in  ABITS  address of the least-significant result word; latched on accepted `start`
- `rd_addr`  out  ABITS  BRAM read address (registered)
- `rd_data`  in  DBITS  BRAM read data, valid one cycle after `rd_addr` is sampled
- `out_data`  out  OBITS  stream beat
- `out_valid`  out  1  beat valid
- `out_ready`  in  1  sink accepts the beat
- `out_last`  out  1  final beat of the result
- `busy`  out  1  high from accepted `start` until the final handshake
- `done`  out  1  one-cycle pulse after the final handshake

## Operation
- FSM states: IDLE, ADDR, CAPT, SEND.
- IDLE: on `start`=1, latch `base_addr` into `rd_addr`, clear the word counter, and go to ADDR.
- ADDR: the BRAM samples `rd_addr` this cycle. Go to CAPT.
- CAPT: load `rd_data` into a DBITS shift register, clear the beat counter, and go to SEND.
- SEND: `out_valid`=1 and `out_data`=low OBITS of the shift register. On `out_valid & out_ready`, shift right by OBITS and increment the beat counter.
  - On the handshake of beat `DBITS/OBITS-1` with more words remaining: `rd_addr <= rd_addr+1` (wraps modulo 2^ABITS), then go to ADDR.
  - On the handshake of the last word's last beat: go to IDLE and pulse `done`.
- `out_last` = SEND & last word & last beat.
- Total beats = `NWORDS*DBITS/OBITS` (32 at the defaults).
- `start` while busy is ignored; it is neither queued nor a restart.

## Timing
- Reset values: `rd_addr`=0, `out_data`=0, `out_valid`=0, `out_last`=0, `busy`=0, `done`=0, state IDLE.
- If `start` is sampled at edge E0, the first `out_valid` is high after E2 (three cycles of latency).
- Each word boundary adds a two-cycle bubble (ADDR, CAPT) with `out_valid`=0.
- Stall: while `out_valid & !out_ready`, the values of `out_data` and `out_last` hold stable. Once `out_valid` rises, it stays high until the handshake.
- `done` is high for exactly the cycle after the final handshake, with `busy`=0 in that cycle. A `start` in that same cycle is accepted.
- `rst_n` low mid-transfer: the block returns to IDLE at once and all outputs take their reset values. No partial `done` is issued.
- `rd_addr` wrap: `base_addr`=255 with `NWORDS`=2 reads address 255 and then address 0.

## Configuration
- `RESULT_UNLOADER_MSB_FIRST_EN` defined:
  - Words are read from `base_addr+NWORDS-1` down to `base_addr`.
  - Each word is emitted most-significant chunk first (shift left, output the high OBITS).
  - `out_last` marks the least-significant chunk of `base_addr`.
- Undefined (default): least-significant word first, least-significant chunk first, as described above.

## Structure
- Shared package `rsa_pkg` holds:
  - `ABITS`/`DBITS` defaults, which must match `bram`/`mon_prod`;
  - the unloader state typedef;
  - `BEATS_PER_WORD = DBITS/OBITS`.
- One sub-module, `word_serializer`: a DBITS-to-OBITS shift register with load, shift-on-handshake and a beat counter whose `last_beat` output feeds the FSM.

## Test plan
- Value in the default address range: preload addr 4 = 435, addr 5 = 0, assert `start` with `base_addr`=4 and `out_ready` tied high.
  - Required: beat 0 = 435, beats 1–31 = 0, `out_last` only on beat 31.
  - Required: the first `out_valid` three cycles after `start`; `done` one cycle after beat 31.
- Mixed words with backpressure: preload addr 0 = 589, addr 1 = 1 (so the value is 2^512+589), and toggle `out_ready` pseudo-randomly.
  - Required: beat 0 = 589, beat 16 = 1, all other beats 0.
  - Required: `out_data` stable across every stall.
- Address wrap: `base_addr`=255 reads addr 255 and then addr 0; check `rd_addr` and the beat order.
- `start` while busy is ignored, with the stream unchanged. A `start` in the `done` cycle begins a new transfer whose first `out_valid` arrives three cycles later.
- Reset mid-transfer: pull `rst_n` low at beat 10. All outputs go to 0 at once and no `done` is issued. A fresh `start` afterwards produces the full 32 beats.
- With `RESULT_UNLOADER_MSB_FIRST_EN` defined, the first test yields beat 0 = 0, beats 0–30 = 0 and beat 31 = 435, with `out_last` on beat 31.
